// File: rtl/ram_stream_reader.sv
// Burst reader for a single-port RAM with one-cycle registered read data. Words
// stream out through a 4-entry FIFO on a valid/ready interface.
// Optional: define RAM_RD_CHECKSUM_EN to add a per-burst checksum output.
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef RAM_RD_CHECKSUM_EN
   ,output logic [DATA_WIDTH-1:0] checksum
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  issue_q, issue_d;
    logic                  rvld_q;

    logic [DATA_WIDTH-1:0] fifo_mem_q [4];
    logic [1:0]            wr_ptr_q, rd_ptr_q;
    logic [2:0]            cnt_q;

    logic start_ok, push, pop, credit_ok, may_issue, drain_ok;

    assign start_ok  = (state_q == S_IDLE) && start;
    assign push      = rvld_q;
    assign pop       = m_valid && m_ready;
    // Credit uses registered occupancy only; a same-cycle pop is not counted,
    // so buffered + in-flight never exceeds the 4 FIFO slots.
    assign credit_ok = (cnt_q + 3'(issue_q) + 3'(rvld_q)) <= 3'd3;
    assign may_issue = (state_q == S_RUN) && (remain_q != '0) && credit_ok;
    // Leave DRAIN as the last word transfers so done lands on the next cycle.
    assign drain_ok  = !issue_q && !rvld_q &&
                       ((cnt_q == 3'd0) || ((cnt_q == 3'd1) && pop));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (length == '0) ? S_FIN : S_RUN;
            S_RUN:   if (remain_q == '0) state_d = S_DRAIN;
            S_DRAIN: if (drain_ok) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_FIN);
    end

    always_comb begin
        addr_d   = addr_q;
        remain_d = remain_q;
        issue_d  = 1'b0;
        if (start_ok && (length != '0)) begin
            addr_d   = base_addr;
            remain_d = length - LEN_WIDTH'(1);
            issue_d  = 1'b1;
        end else if (may_issue) begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            remain_d = remain_q - LEN_WIDTH'(1);
            issue_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            remain_q <= '0;
            issue_q  <= 1'b0;
            rvld_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            remain_q <= remain_d;
            issue_q  <= issue_d;
            rvld_q   <= issue_q;
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= ram_q;
    end

    assign ram_a   = addr_q;
    assign ram_we  = 1'b0;
    assign ram_d   = '0;
    assign m_valid = (cnt_q != 3'd0);
    assign m_data  = fifo_mem_q[rd_ptr_q];

`ifdef RAM_RD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst)           sum_q <= '0;
        else if (start_ok) sum_q <= '0;
        else if (pop)      sum_q <= sum_q + m_data;
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: random bursts against a queue model
// of the expected word stream, plus directed timing, wrap, stall and reset cases.
module tb_ram_stream_reader;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy, done, ram_we, m_valid, m_ready;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d, ram_q, m_data;
`ifdef RAM_RD_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mode = 0;
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_sum;

    ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d),
        .ram_q(ram_q), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef RAM_RD_CHECKSUM_EN
       ,.checksum(checksum)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ram_q <= mem[ram_a];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // m_ready generator: always-ready, random, or a fixed pattern with a 5-cycle stall
    initial begin
        logic [11:0] pat;
        int p;
        pat = 12'b1100_0001_1001;
        p = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = pat[p % 12];
            endcase
            p++;
        end
    end

    // Monitor: pop the scoreboard on every transfer, check hold during stalls
    initial begin
        logic          pv, pr;
        logic [DW-1:0] pd, e;
        pv = 1'b0; pr = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pv && !pr) begin
                    check("stall_valid_hold", 32'(m_valid), 32'd1);
                    check("stall_data_hold", 32'(m_data), 32'(pd));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_data", 32'(m_data), 32'(e));
                    end
                end
            end
            pv = m_valid && !rst;
            pr = m_ready;
            pd = m_data;
        end
    end

    task automatic start_burst(input int base, input int len, output int c0);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = AW'(base);
        length = LW'(len);
        c0 = cyc;
        exp_sum = '0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(mem[(base + i) % 1024]);
            exp_sum = exp_sum + mem[(base + i) % 1024];
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc, output bit saw_valid);
        int n;
        n = 0;
        dcyc = -1;
        saw_valid = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            if (m_valid) saw_valid = 1'b1;
            if (done) begin
                dcyc = cyc;
                break;
            end
            n++;
        end
        if (dcyc < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_checks(input string nm);
        check({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
`ifdef RAM_RD_CHECKSUM_EN
        check({nm, "_checksum"}, 32'(checksum), 32'(exp_sum));
`endif
        @(negedge clk);
        check({nm, "_done_pulse"}, 32'(done), 32'd0);
        check({nm, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int c0, d, ra, len, base;
        bit sv;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i + 'h100);
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_ram_a", 32'(ram_a), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_d", 32'(ram_d), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // base=5, length=4, always ready: exact address and done timing
        mode = 0;
        start_burst(5, 4, c0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("seq_ram_a", 32'(ram_a), 32'(5 + i));
            check("seq_busy", 32'(busy), 32'd1);
        end
        wait_done(50, d, sv);
        check("seq_done_cycle", 32'(d - c0), 32'd7);
        finish_checks("seq");

        // Address wrap at the top of the RAM
        start_burst(1022, 4, c0);
        wait_done(50, d, sv);
        check("wrap_done_cycle", 32'(d - c0), 32'd7);
        finish_checks("wrap");

        // Zero length: done in cycle 1, no stream, address untouched
        ra = int'(ram_a);
        start_burst(77, 0, c0);
        wait_done(20, d, sv);
        check("len0_done_cycle", 32'(d - c0), 32'd1);
        check("len0_no_valid", 32'(sv), 32'd0);
        check("len0_ram_a", 32'(ram_a), 32'(ra));
        finish_checks("len0");

        // 16 words under a stalling pattern, with an ignored start mid-burst
        mode = 2;
        start_burst(300, 16, c0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; base_addr = AW'(0); length = LW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2000, d, sv);
        finish_checks("stall16");

        // Reset with two reads in flight, then a clean short burst
        mode = 0;
        start_burst(100, 8, c0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
`ifdef RAM_RD_CHECKSUM_EN
        check("midrst_checksum", 32'(checksum), 32'd0);
`endif
        start_burst(0, 2, c0);
        wait_done(50, d, sv);
        check("postrst_done_cycle", 32'(d - c0), 32'd5);
        finish_checks("postrst");

        // Random bursts under random backpressure modes
        for (int t = 0; t < 10; t++) begin
            mode = int'($urandom_range(0, 2));
            base = int'($urandom_range(0, 1023));
            len = int'($urandom_range(1, 40));
            start_burst(base, len, c0);
            wait_done(len * 20 + 50, d, sv);
            if (mode == 0) check("rand_done_cycle", 32'(d - c0), 32'(len + 3));
            finish_checks("rand");
        end

        // Whole RAM in one burst
        mode = 0;
        base = int'($urandom_range(0, 1023));
        start_burst(base, 1024, c0);
        wait_done(1200, d, sv);
        check("full_done_cycle", 32'(d - c0), 32'd1027);
        finish_checks("full");

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side initiator for the single-port inferred weight/activation RAM (registered read data, one-cycle read latency).
- On a start command, it walks a contiguous address range and drives the RAM address port.
- It captures the registered read data and presents each word on a valid/ready stream to the downstream NN datapath (MAC array, layer sequencer).
- It absorbs downstream backpressure without losing words and without stalling the RAM pipeline mid-read.

Parameters:
ADDR_WIDTH, 10, RAM address width; addresses wrap modulo 2^ADDR_WIDTH
DATA_WIDTH, 16, RAM / stream word width
LEN_WIDTH, 11, width of the length field; allows 0..1024 words for the default RAM

Ports:
clk  input  1  rising-edge clock, shared with the RAM
rst  input  1  synchronous active-high reset
start  input  1  one-cycle command strobe; sampled only in IDLE
base_addr  input  ADDR_WIDTH  first word address; sampled with start
length  input  LEN_WIDTH  number of words to read; sampled with start
busy  output  1  high from the cycle after an accepted start until the cycle done is high (inclusive)
done  output  1  one-cycle pulse when the burst completes
ram_a  output  ADDR_WIDTH  RAM address, registered
ram_we  output  1  RAM write enable; constant 0
ram_d  output  DATA_WIDTH  RAM write data; constant 0
ram_q  input  DATA_WIDTH  RAM registered read data
m_data  output  DATA_WIDTH  stream data, taken from the head of the output FIFO
m_valid  output  1  stream valid
m_ready  input  1  stream ready from downstream

Behaviour:
- Reset values: busy=0, done=0, m_valid=0, ram_a=0, FIFO empty, in-flight count 0, state IDLE. ram_we and ram_d are always 0.
- States:
  - IDLE. An accepted start (start=1) with length>0 goes to RUN; with length=0 goes to FIN.
  - RUN. Issues reads until `length` addresses have been issued, then goes to DRAIN.
  - DRAIN. Waits until in-flight count and FIFO are both empty and the last word has been accepted, then goes to FIN.
  - FIN. done=1 for one cycle, then IDLE.
- Read pipeline:
  - Address issued in cycle k (ram_a valid during k).
  - RAM samples it at the end of k; ram_q is valid in cycle k+1.
  - The word is written into the 4-entry FIFO at the end of k+1 and is visible on m_data/m_valid in cycle k+2.
  - In-flight count covers issued-but-not-yet-in-FIFO reads (max 2).
- Issue rule: in RUN, issue the next address only when FIFO occupancy + in-flight count ≤ 3, evaluated on registered state (a same-cycle pop is not credited). This guarantees no FIFO overflow under arbitrary m_ready.
- Address sequence: base_addr, base_addr+1, …, base_addr+length−1, each modulo 2^ADDR_WIDTH. Wrap from 2^ADDR_WIDTH−1 to 0 is legal.
- Latency: start sampled at the end of cycle 0 → ram_a=base_addr in cycle 1 → first m_valid in cycle 3.
- Throughput: with m_ready held high, one word per cycle, no bubbles.
- Stream rules:
  - A word transfers when m_valid && m_ready.
  - m_data is stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer.
- done: asserted in the cycle after the last word transfers. For length=0, done is high in cycle 1 with no RAM activity.
- start while busy is ignored; no queuing.
- Simultaneous FIFO push and pop: occupancy is unchanged and both operations take effect.
- rst mid-burst: all in-flight and buffered words are discarded; m_valid=0 and busy=0 from the next cycle. A late ram_q is ignored.
- Length counter is LEN_WIDTH wide. The issued-address counter must not overflow for length=2^ADDR_WIDTH, where the full RAM is read once.

Optional Feature:
- Macro: RAM_RD_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (DATA_WIDTH), the modulo-2^DATA_WIDTH sum of all words transferred on the stream in the current burst.
  - Cleared to 0 on an accepted start.
  - Final value is valid in the cycle done=1 and holds until the next accepted start or rst. Reset value is 0.
- Undefined: the port and the adder are absent; all other behaviour is identical.

Test Plan:
- Preload mem[i]=i+0x100. Start with base=5, length=4, m_ready=1 → ram_a 5,6,7,8 in cycles 1–4; m_data 0x105..0x108 in cycles 3–6; done in cycle 7; checksum=0x41A if enabled.
- base=1022, length=4, m_ready=1 → addresses 1022,1023,0,1; data 0x4FE,0x4FF,0x100,0x101.
- length=16 with m_ready toggling 1,0,0,1,… and 5-cycle stalls → all 16 words delivered in order, none duplicated or dropped; FIFO occupancy never exceeds 4; m_data stable during stalls.
- length=0 → done in cycle 1; m_valid never asserted; ram_a unchanged.
- start pulsed again mid-burst → ignored; the original burst completes unchanged.
- rst asserted mid-burst with 2 reads in flight → m_valid=0 and busy=0 next cycle. A subsequent start with base=0, length=2 delivers 0x100,0x101 only.
